// File: rtl/dps_dec23_seq_ctrl.sv
// Bit-serial DPS decoder: accumulates one codeword bit per cycle against a
// Fibonacci weight generated on the fly, with valid/ready on both sides.
module dps_dec23_seq_ctrl #(
    parameter int N  = 23,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  codein,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          busy
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_PEN  = KW'(N - 2);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [DW-1:0]   nxt_q, nxt_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [DW-1:0]   weight;
    logic [DW-1:0]   acc_sum;

    // The shadow word shifts right each RUN cycle, so bit 0 is always bit k.
    always_comb begin
        weight  = (k_q == K_PEN) ? (cur_q << 1) : cur_q;
        acc_sum = acc_q + (shadow_q[0] ? weight : '0);
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        dout_d   = dout_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    shadow_d = codein;
                    acc_d    = '0;
                    k_d      = '0;
                    cur_d    = DW'(1);
                    nxt_d    = DW'(1);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                shadow_d = shadow_q >> 1;
                cur_d    = nxt_q;
                nxt_d    = cur_q + nxt_q;
                k_d      = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    dout_d  = acc_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered so it stays low for the first cycle after reset release.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            k_q        <= '0;
            shadow_q   <= '0;
            acc_q      <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            k_q        <= k_d;
            shadow_q   <= shadow_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            dout_q     <= dout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign dataout   = dout_q;

endmodule

// File: tb/tb_dps_dec23_seq_ctrl.sv
// Randomized bench for dps_dec23_seq_ctrl against a transaction-level model
// of the weighted Fibonacci sum and the accept-to-result timing.
module tb_dps_dec23_seq_ctrl;

    localparam int N  = 23;
    localparam int DW = 17;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  codein;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dataout;
    logic          busy;

    dps_dec23_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codein    (codein),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: weighted sum from the Fibonacci definition.
    function automatic logic [DW-1:0] ref_decode(input logic [N-1:0] w);
        longint fns [1:N];
        longint sum;
        longint wt;
        fns[1] = 1;
        fns[2] = 1;
        for (int j = 3; j <= N; j++) fns[j] = fns[j-1] + fns[j-2];
        sum = 0;
        for (int k = 0; k < N; k++) begin
            if (k <= N - 3)      wt = fns[k+1];
            else if (k == N - 2) wt = 2 * fns[N-1];
            else                 wt = fns[N];
            if (w[k]) sum += wt;
        end
        return DW'(sum);
    endfunction

    // Transaction model state, updated by the compare process only.
    bit            started     = 0;
    bit            prev_rst_low = 0;
    bit            have_word   = 0;
    logic [N-1:0]  model_word;
    int            acc_cyc;
    int            cyc         = 0;
    int            accepted    = 0;
    int            retired     = 0;
    int            accepts[$];

    initial begin
        bit exp_ov;
        bit exp_ir;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst_low) begin
                started   = 1;
                have_word = 0;
                check("rst_in_ready", in_ready, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_dataout", dataout, 0);
            end else if (started) begin
                exp_ov = have_word && (cyc >= acc_cyc + N + 1);
                exp_ir = !have_word;
                check("in_ready", in_ready, exp_ir);
                check("out_valid", out_valid, exp_ov);
                check("busy", busy, have_word);
                if (exp_ov) check("dataout", dataout, ref_decode(model_word));
                if (rst_n) begin
                    if (exp_ov && out_ready) begin
                        have_word = 0;
                        retired++;
                    end else if (exp_ir && in_valid) begin
                        have_word  = 1;
                        model_word = codein;
                        acc_cyc    = cyc;
                        accepted++;
                        accepts.push_back(cyc);
                    end
                end
            end
            prev_rst_low = !rst_n;
        end
    end

    bit rand_or  = 0;
    bit or_fixed = 1;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_or ? ($urandom_range(3) != 0) : or_fixed;
        end
    end

    int sent = 0;

    task automatic send(input logic [N-1:0] w, input bit hold_after);
        int cnt;
        codein   = w;
        in_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 300);
        if (!in_ready) check("accept_timeout", 0, 1);
        sent++;
        @(posedge clk);
        #1;
        if (!hold_after) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (busy && cnt < 300);
        if (busy) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [N-1:0] w, input logic [DW-1:0] exp);
        int cnt;
        send(w, 0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 300);
        check("latency", cnt, N + 1);
        check("word_result", dataout, exp);
        wait_idle();
    endtask

    initial begin
        int base;
        logic [DW-1:0] held;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        codein   = '0;

        check("model_ones", ref_decode(23'h7FFFFF), 92735);
        check("model_b21", ref_decode(23'h200000), 35422);
        check("model_alt", ref_decode(23'h155555), 17711);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_word(23'h000000, 0);
        run_word(23'h7FFFFF, 92735);
        run_word(23'h000001, 1);
        run_word(23'h000004, 2);
        run_word(23'h100000, 10946);
        run_word(23'h200000, 35422);
        run_word(23'h400000, 28657);

        // Back-to-back with in_valid held high.
        base = accepts.size();
        send(23'h0ABCDE, 1);
        send(23'h123456, 1);
        send(23'h7F00FF, 1);
        send(23'h000F0F, 0);
        wait_idle();
        for (int i = base + 1; i < accepts.size(); i++)
            check("accept_period", accepts[i] - accepts[i-1], N + 2);

        // Backpressure in DONE with junk on the input side.
        or_fixed = 1'b0;
        send(23'h2AAAAA, 0);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        held = dataout;
        check("bp_result", held, ref_decode(23'h2AAAAA));
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            in_valid = 1'b1;
            codein   = N'($urandom);
            @(negedge clk);
            check("bp_hold", dataout, held);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        or_fixed = 1'b1;
        wait_idle();

        // Reset while k = 10.
        send(23'h3C3C3C, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_word(23'h155555, 17711);

        // Random words with random gaps and backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
            case ($urandom_range(7))
                0:       send(23'h7FFFFF, 0);
                1:       send(N'(1) << $urandom_range(N - 1), 0);
                default: send(N'($urandom), 0);
            endcase
        end
        rand_or = 1'b0;
        wait_idle();

        check("accepted_count", accepted, sent);
        check("retired_count", retired, sent - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
